// File: rtl/chunked_serial_adder_pkg.sv
// Shared FSM state type and sizing helper for the chunked serial adder.
package adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // The chunk index needs at least one bit, even when there is a single chunk.
    function automatic int unsigned idx_width(input int unsigned nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/chunked_serial_adder_cla_chunk.sv
// Combinational CHUNK-bit carry-lookahead slice, reused every cycle by the serial adder.
module cla_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK-1:0] gen;
    logic [CHUNK-1:0] prop;
    logic [CHUNK:0]   c;

    assign gen  = a & b;
    assign prop = a | b;

    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            c[i+1] = gen[i] | (prop[i] & c[i]);
        end
    end

    assign sum   = a ^ b ^ c[CHUNK-1:0];
    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one CHUNK-bit lookahead slice per clock, carry registered
// between chunks, valid/ready handshakes on both sides.
module chunked_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_width
        $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

    logic [CHUNK-1:0] a_chunk, b_chunk, chunk_sum;
    logic             chunk_cout, chunk_cmsb;

    assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
    assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];

    cla_chunk #(.CHUNK(CHUNK)) u_slice (
        .a     (a_chunk),
        .b     (b_chunk),
        .cin   (carry_q),
        .sum   (chunk_sum),
        .cout  (chunk_cout),
        .c_msb (chunk_cmsb)
    );

    assign in_ready     = (state_q == IDLE) && !rst;
    assign out_valid    = (state_q == DONE);
    assign out_sum      = sum_q;
    assign out_carry    = cout_q;
    assign out_overflow = ovf_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_carry;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[idx_q*CHUNK +: CHUNK] = chunk_sum;
                carry_d = chunk_cout;
                // Output registers only change on completion, so the previous result stays visible.
                if (idx_q == LAST) begin
                    sum_d   = res_d;
                    cout_d  = chunk_cout;
                    ovf_d   = chunk_cout ^ chunk_cmsb;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench for chunked_serial_adder: directed table and corner sequences on the
// 32/8 configuration, then scoreboarded random traffic on 32/8, 8/8 and 64/16.
module tb_chunked_serial_adder;

    localparam int unsigned NCFG  = 3;
    localparam int unsigned CW [NCFG] = '{32, 8, 64};
    localparam int unsigned CC [NCFG] = '{8, 8, 16};
    localparam int unsigned NRAND = 1000;

    typedef struct packed {
        logic [63:0] sum;
        logic        carry;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] esum;
        logic        ecarry;
        logic        eovf;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NCFG-1:0][63:0] a_s, b_s, sum_s;
    logic [NCFG-1:0] cin_s, iv_s, ir_s, ov_s, or_s, co_s, of_s;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    vec_t tbl[8];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        logic [CW[g]-1:0] sum_w;
        chunked_serial_adder #(.WIDTH(CW[g]), .CHUNK(CC[g])) u_dut (
            .clk          (clk),
            .rst          (rst),
            .in_valid     (iv_s[g]),
            .in_ready     (ir_s[g]),
            .in_a         (a_s[g][CW[g]-1:0]),
            .in_b         (b_s[g][CW[g]-1:0]),
            .in_carry     (cin_s[g]),
            .out_valid    (ov_s[g]),
            .out_ready    (or_s[g]),
            .out_sum      (sum_w),
            .out_carry    (co_s[g]),
            .out_overflow (of_s[g])
        );
        assign sum_s[g] = 64'(sum_w);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: wide integer addition, signed overflow from operand/result sign bits.
    function automatic res_t model(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin);
        logic [64:0] tot;
        logic [63:0] mask;
        res_t        r;
        mask    = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        tot     = {1'b0, a & mask} + {1'b0, b & mask} + 65'(cin);
        r.sum   = tot[63:0] & mask;
        r.carry = tot[w];
        r.ovf   = (a[w-1] == b[w-1]) && (r.sum[w-1] != a[w-1]);
        return r;
    endfunction

    function automatic logic [63:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic compare_out(input int unsigned g, input string tag);
        res_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_spurious_valid"}, 64'(ov_s[g]), 64'd0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_sum"}, sum_s[g], e.sum);
        check({tag, "_carry"}, 64'(co_s[g]), 64'(e.carry));
        check({tag, "_ovf"}, 64'(of_s[g]), 64'(e.ovf));
    endtask

    // Directed op on the 32/8 instance; entered and left at 1 time unit after a rising edge.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input res_t exp, input bit rel, input string tag);
        int unsigned n;
        n = 0;
        while (!ir_s[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_in_ready"}, 64'(ir_s[0]), 64'd1);
        a_s[0]   = a;
        b_s[0]   = b;
        cin_s[0] = cin;
        iv_s[0]  = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        iv_s[0] = 1'b0;
        a_s[0]  = ~a;
        b_s[0]  = ~b;
        n = 0;
        while (!ov_s[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd4);
        compare_out(0, tag);
        if (rel) begin
            or_s[0] = 1'b1;
            @(posedge clk); #1;
            or_s[0] = 1'b0;
            check({tag, "_idle_in_ready"}, 64'(ir_s[0]), 64'd1);
            check({tag, "_idle_out_valid"}, 64'(ov_s[0]), 64'd0);
            check({tag, "_held_sum"}, sum_s[0], exp.sum);
        end
    endtask

    task automatic run_random(input int unsigned g);
        int unsigned sent, cyc;
        string       tag;
        sent = 0;
        cyc  = 0;
        tag  = $sformatf("rand_w%0d_c%0d", CW[g], CC[g]);
        exp_q.delete();
        @(negedge clk);
        while ((sent < NRAND || exp_q.size() != 0) && cyc < 40000) begin
            if (sent < NRAND) begin
                iv_s[g]  = ($urandom_range(0, 9) < 7);
                a_s[g]   = rand_op();
                b_s[g]   = rand_op();
                cin_s[g] = 1'($urandom_range(0, 1));
            end else begin
                iv_s[g] = 1'b0;
            end
            or_s[g] = ($urandom_range(0, 9) < 6);
            #1;
            if (iv_s[g] && ir_s[g]) begin
                exp_q.push_back(model(CW[g], a_s[g], b_s[g], cin_s[g]));
                sent++;
            end
            if (ov_s[g] && or_s[g]) compare_out(g, tag);
            @(negedge clk);
            cyc++;
        end
        iv_s[g] = 1'b0;
        or_s[g] = 1'b0;
        check({tag, "_accepted"}, 64'(sent), 64'(NRAND));
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        res_t e;
        iv_s  = '0;
        or_s  = '0;
        a_s   = '0;
        b_s   = '0;
        cin_s = '0;

        tbl[0] = '{64'h0000_00FF, 64'h0000_0001, 1'b0, 64'h0000_0100, 1'b0, 1'b0, "basic"};
        tbl[1] = '{64'hFFFF_FFFF, 64'h0000_0000, 1'b1, 64'h0000_0000, 1'b1, 1'b0, "ripple"};
        tbl[2] = '{64'h7FFF_FFFF, 64'h0000_0001, 1'b0, 64'h8000_0000, 1'b0, 1'b1, "ovf_pos"};
        tbl[3] = '{64'h8000_0000, 64'h8000_0000, 1'b0, 64'h0000_0000, 1'b1, 1'b1, "ovf_neg"};
        tbl[4] = '{64'h1234_5678, 64'h1111_1111, 1'b0, 64'h2345_6789, 1'b0, 1'b0, "plain"};
        tbl[5] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF, 1'b1, 1'b0, "neg_one"};
        tbl[6] = '{64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 64'h7FFF_FFFF, 1'b1, 1'b1, "mixed_ovf"};
        tbl[7] = '{64'h00FF_00FF, 64'h0001_0001, 1'b0, 64'h0100_0100, 1'b0, 1'b0, "chunk_carry"};

        repeat (3) @(posedge clk);
        #1;
        for (int unsigned g = 0; g < NCFG; g++) begin
            check($sformatf("rst_in_ready_%0d", g), 64'(ir_s[g]), 64'd0);
            check($sformatf("rst_out_valid_%0d", g), 64'(ov_s[g]), 64'd0);
            check($sformatf("rst_sum_%0d", g), sum_s[g], 64'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        for (int unsigned g = 0; g < NCFG; g++) begin
            check($sformatf("post_rst_in_ready_%0d", g), 64'(ir_s[g]), 64'd1);
            check($sformatf("post_rst_flags_%0d", g), 64'({co_s[g], of_s[g]}), 64'd0);
        end

        foreach (tbl[i]) begin
            e = '{tbl[i].esum, tbl[i].ecarry, tbl[i].eovf};
            do_op(tbl[i].a, tbl[i].b, tbl[i].cin, e, 1'b1, tbl[i].name);
        end

        // Backpressure: result must hold while new operands are offered and refused.
        e = '{64'h8000_0000, 1'b0, 1'b1};
        do_op(64'h7FFF_FFFF, 64'h1, 1'b0, e, 1'b0, "bp");
        for (int i = 0; i < 5; i++) begin
            iv_s[0] = 1'b1;
            a_s[0]  = {$urandom, $urandom};
            b_s[0]  = {$urandom, $urandom};
            @(posedge clk); #1;
            check("bp_out_valid", 64'(ov_s[0]), 64'd1);
            check("bp_in_ready", 64'(ir_s[0]), 64'd0);
            check("bp_sum", sum_s[0], 64'h8000_0000);
            check("bp_flags", 64'({co_s[0], of_s[0]}), 64'b01);
        end
        or_s[0] = 1'b1;
        @(posedge clk); #1;
        iv_s[0] = 1'b0;
        or_s[0] = 1'b0;
        check("bp_release_in_ready", 64'(ir_s[0]), 64'd1);
        check("bp_release_out_valid", 64'(ov_s[0]), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check("bp_no_handoff_accept", 64'(ov_s[0]), 64'd0);

        // Reset after chunk 1 of an op: aborted, outputs cleared.
        a_s[0]   = 64'hFFFF_FFFF;
        b_s[0]   = 64'h0;
        cin_s[0] = 1'b1;
        iv_s[0]  = 1'b1;
        @(posedge clk); #1;
        iv_s[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", 64'(ov_s[0]), 64'd0);
        check("midrst_sum", sum_s[0], 64'd0);
        check("midrst_flags", 64'({co_s[0], of_s[0]}), 64'd0);
        check("midrst_in_ready_during", 64'(ir_s[0]), 64'd0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready_after", 64'(ir_s[0]), 64'd1);
        e = '{64'h2345_6789, 1'b0, 1'b0};
        do_op(64'h1234_5678, 64'h1111_1111, 1'b0, e, 1'b1, "after_rst");

        for (int unsigned g = 0; g < NCFG; g++) begin
            run_random(g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
